// File: rtl/srv32_dbus_router.sv
// Data-bus router between the srv32 core data port and NUM_TGT slaves.
// Address-decoded writes, in-order tracked reads, and decode-error reporting.
module srv32_dbus_router #(
  parameter int unsigned                NUM_TGT     = 2,
  parameter int unsigned                SEL_W       = 4,
  parameter logic [NUM_TGT*SEL_W-1:0]   TGT_BASE    = {4'h9, 4'h0},
  parameter int unsigned                DEFAULT_TGT = 0,
  parameter int unsigned                RD_DEPTH    = 2,
  parameter int unsigned                ERR_CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     c_wready,
  output logic                     c_wvalid,
  input  logic [31:0]              c_waddr,
  input  logic [31:0]              c_wdata,
  input  logic [3:0]               c_wstrb,
  input  logic                     c_rready,
  output logic                     c_rvalid,
  input  logic [31:0]              c_raddr,
  output logic                     c_rdv,
  output logic                     c_rresp,
  output logic [31:0]              c_rdata,
  output logic [NUM_TGT-1:0]       t_wready,
  input  logic [NUM_TGT-1:0]       t_wvalid,
  output logic [31:0]              t_waddr,
  output logic [31:0]              t_wdata,
  output logic [3:0]               t_wstrb,
  output logic [NUM_TGT-1:0]       t_rready,
  input  logic [NUM_TGT-1:0]       t_rvalid,
  output logic [31:0]              t_raddr,
  input  logic [NUM_TGT-1:0]       t_rdv,
  input  logic [NUM_TGT-1:0]       t_rresp,
  input  logic [NUM_TGT*32-1:0]    t_rdata,
  output logic                     dec_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam int unsigned IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int unsigned PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RD_DEPTH + 1);
  localparam int unsigned EW = ERR_CNT_W + 1;

  // Route code: {unmapped flag, target index}; unmapped codes always carry index 0.
  typedef logic [IW:0] code_t;

  function automatic code_t decode(input logic [31:0] a);
    code_t r;
    r = {1'b1, {IW{1'b0}}};
    if (DEFAULT_TGT < NUM_TGT) r = {1'b0, IW'(DEFAULT_TGT)};
    for (int unsigned i = NUM_TGT; i > 0; i--) begin
      if (a[31 -: SEL_W] == TGT_BASE[(i-1)*SEL_W +: SEL_W]) r = {1'b0, IW'(i - 1)};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  code_t                fifo_q [RD_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 dec_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [EW-1:0]        err_sum;

  code_t code_w, code_r, head, newest;
  logic  empty, full, gate_r, push, pop, err_w, err_r;

  assign t_waddr = c_waddr;
  assign t_wdata = c_wdata;
  assign t_wstrb = c_wstrb;
  assign t_raddr = c_raddr;
  assign dec_err = dec_err_q;
  assign err_cnt = err_cnt_q;

  always_comb begin
    code_w = decode(c_waddr);
    code_r = decode(c_raddr);
    empty  = (cnt_q == '0);
    full   = (cnt_q == CW'(RD_DEPTH));
    head   = fifo_q[rd_ptr_q];
    newest = fifo_q[(wr_ptr_q == '0) ? PW'(RD_DEPTH - 1) : wr_ptr_q - 1'b1];

    c_wvalid = 1'b0;
    t_wready = '0;
    err_w    = 1'b0;
    if (c_wready) begin
      if (code_w[IW]) begin
        c_wvalid = 1'b1;
        err_w    = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
          if (code_w[IW-1:0] == IW'(i)) begin
            t_wready[i] = 1'b1;
            c_wvalid    = t_wvalid[i];
          end
        end
      end
    end

    // A new read may only follow reads to the same route, so responses return in order.
    gate_r   = full || (!empty && (newest != code_r));
    c_rvalid = 1'b0;
    t_rready = '0;
    err_r    = 1'b0;
    if (c_rready && !gate_r) begin
      if (code_r[IW]) begin
        c_rvalid = 1'b1;
        err_r    = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
          if (code_r[IW-1:0] == IW'(i)) begin
            t_rready[i] = 1'b1;
            c_rvalid    = t_rvalid[i];
          end
        end
      end
    end

    c_rdv   = 1'b0;
    c_rresp = 1'b0;
    c_rdata = '0;
    if (!empty) begin
      if (head[IW]) begin
        c_rdv = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
          if ((head[IW-1:0] == IW'(i)) && t_rdv[i]) begin
            c_rdv   = 1'b1;
            c_rresp = t_rresp[i];
            c_rdata = t_rdata[i*32 +: 32];
          end
        end
      end
    end

    push      = c_rvalid;
    pop       = c_rdv;
    err_sum   = {1'b0, err_cnt_q} + EW'(err_w) + EW'(err_r);
    err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      dec_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q     <= cnt_q + CW'(push) - CW'(pop);
      dec_err_q <= err_w | err_r;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= code_r;
  end

endmodule
